// File: rtl/ic_mw_pkg.sv
// Shared types and constants for the IC Avalon-MM write master.
package ic_mw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } mw_state_e;

    localparam logic [2:0] INC_WORD = 3'd4;
    localparam logic [2:0] INC_HW   = 3'd2;
    localparam logic [2:0] INC_BYTE = 3'd1;

    localparam logic [2:0] AINC_WORD = 3'b100;
    localparam logic [2:0] AINC_HW   = 3'b010;
    localparam logic [2:0] AINC_BYTE = 3'b001;

    // Unrecognised unit selects fall back to whole-word transfers.
    function automatic logic [2:0] inc_decode(input logic [2:0] code);
        case (code)
            AINC_HW:   return INC_HW;
            AINC_BYTE: return INC_BYTE;
            default:   return INC_WORD;
        endcase
    endfunction

endpackage

// File: rtl/ic_mw_lane_steer.sv
// Replicates the write data across byte lanes and selects the enables for the
// current transfer unit and low address bits.
module ic_mw_lane_steer
    import ic_mw_pkg::*;
(
    input  logic [31:0] data_r,
    input  logic [2:0]  inc,
    input  logic [1:0]  addr,
    output logic [31:0] MW_writedata,
    output logic [3:0]  MW_byteenable
);

    always_comb begin
        MW_writedata  = '0;
        MW_byteenable = '0;
        case (inc)
            INC_WORD: begin
                MW_writedata  = data_r;
                MW_byteenable = 4'b1111;
            end
            INC_HW: begin
                MW_writedata  = {2{data_r[15:0]}};
                MW_byteenable = addr[1] ? 4'b1100 : 4'b0011;
            end
            INC_BYTE: begin
                MW_writedata  = {4{data_r[7:0]}};
                MW_byteenable = 4'b0001 << addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ic_master_write.sv
// Avalon-MM write master: drains the encoder output FIFO to memory from
// dest_address, reports completion and the total byte count.
module ic_master_write
    import ic_mw_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              MW_start,
    input  logic [ADDR_W-1:0] dest_address,
    input  logic [2:0]        address_inc,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_q,
    input  logic              fifo_last,
    output logic              fifo_rdreq,
    output logic [ADDR_W-1:0] MW_address,
    output logic              MW_write,
    output logic [DATA_W-1:0] MW_writedata,
    output logic [3:0]        MW_byteenable,
    input  logic              MW_waitrequest,
    output logic              MW_done,
    output logic [ADDR_W-1:0] IC_ByteCount
);

    mw_state_e         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;
    logic [2:0]        inc_q;

    logic              accept;
    logic              pop_fetch;
    logic              pop_write;
    logic [ADDR_W-1:0] inc_ext;

    assign accept    = (state_q == WRITE) && !MW_waitrequest;
    assign pop_fetch = (state_q == FETCH) && !fifo_empty;
    // Refill straight from the head on accept so a full FIFO streams 1 word/clk.
    assign pop_write = accept && !last_q && !fifo_empty;
    assign inc_ext   = ADDR_W'(inc_q);

    assign fifo_rdreq   = pop_fetch || pop_write;
    assign MW_write     = (state_q == WRITE);
    assign MW_done      = (state_q == DONE);
    assign MW_address   = addr_q;
    assign IC_ByteCount = cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            inc_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MW_start) begin
                        addr_q  <= dest_address;
                        inc_q   <= inc_decode(address_inc);
                        cnt_q   <= '0;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (!fifo_empty) begin
                        data_q  <= fifo_q;
                        last_q  <= fifo_last;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        addr_q <= addr_q + inc_ext;
                        cnt_q  <= cnt_q + inc_ext;
                        if (last_q) begin
                            state_q <= DONE;
                        end else if (!fifo_empty) begin
                            data_q <= fifo_q;
                            last_q <= fifo_last;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    ic_mw_lane_steer u_lane_steer (
        .data_r        (data_q[31:0]),
        .inc           (inc_q),
        .addr          (addr_q[1:0]),
        .MW_writedata  (MW_writedata),
        .MW_byteenable (MW_byteenable)
    );

endmodule

// File: tb/tb_ic_master_write.sv
// Scoreboard bench for ic_master_write: a modelled show-ahead FIFO feeds the
// DUT, expected Avalon writes are queued on push and checked on accept.
module tb_ic_master_write;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        MW_start = 1'b0;
    logic [31:0] dest_address = '0;
    logic [2:0]  address_inc = 3'b100;
    logic        fifo_empty;
    logic [31:0] fifo_q;
    logic        fifo_last;
    logic        fifo_rdreq;
    logic [31:0] MW_address;
    logic        MW_write;
    logic [31:0] MW_writedata;
    logic [3:0]  MW_byteenable;
    logic        MW_waitrequest = 1'b0;
    logic        MW_done;
    logic [31:0] IC_ByteCount;

    ic_master_write #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .MW_start       (MW_start),
        .dest_address   (dest_address),
        .address_inc    (address_inc),
        .fifo_empty     (fifo_empty),
        .fifo_q         (fifo_q),
        .fifo_last      (fifo_last),
        .fifo_rdreq     (fifo_rdreq),
        .MW_address     (MW_address),
        .MW_write       (MW_write),
        .MW_writedata   (MW_writedata),
        .MW_byteenable  (MW_byteenable),
        .MW_waitrequest (MW_waitrequest),
        .MW_done        (MW_done),
        .IC_ByteCount   (IC_ByteCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO model
    logic [32:0] mem [64];
    logic [7:0]  wr_ptr = '0;
    logic [7:0]  rd_ptr = '0;
    int          pop_total = 0;
    int          cyc = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign {fifo_last, fifo_q} = mem[rd_ptr[5:0]];

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
        if (!reset_n) rd_ptr <= wr_ptr;
        else if (fifo_rdreq) begin
            rd_ptr <= rd_ptr + 8'd1;
            pop_total <= pop_total + 1;
        end
    end

    // Stall generator: hold waitrequest for stall_len cycles on the write whose
    // index equals stall_target.
    int acc_total = 0;
    int stall_target = -1;
    int stall_len = 0;
    int stall_cnt = 0;

    initial forever begin
        @(posedge clk);
        #2;
        if (MW_write && acc_total == stall_target && stall_cnt < stall_len) begin
            MW_waitrequest = 1'b1;
            stall_cnt++;
        end else begin
            MW_waitrequest = 1'b0;
            if (acc_total != stall_target) stall_cnt = 0;
        end
    end

    // Scoreboard and reference model
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          acc_log[$];
    int          rise_log[$];
    int          done_total = 0;
    logic [31:0] m_addr;
    logic [31:0] m_inc;
    logic [31:0] m_cnt;
    int          start_cyc;

    task automatic lanes(input logic [31:0] d, input logic [31:0] inc, input logic [1:0] a,
                         output logic [31:0] wd, output logic [3:0] be);
        case (inc)
            32'd2: begin
                wd = {d[15:0], d[15:0]};
                be = a[1] ? 4'b1100 : 4'b0011;
            end
            32'd1: begin
                wd = {d[7:0], d[7:0], d[7:0], d[7:0]};
                case (a)
                    2'd0: be = 4'b0001;
                    2'd1: be = 4'b0010;
                    2'd2: be = 4'b0100;
                    default: be = 4'b1000;
                endcase
            end
            default: begin
                wd = d;
                be = 4'b1111;
            end
        endcase
    endtask

    task automatic begin_stream(input logic [31:0] dest, input logic [2:0] code);
        m_addr = dest;
        m_cnt  = '0;
        case (code)
            3'b010:  m_inc = 32'd2;
            3'b001:  m_inc = 32'd1;
            default: m_inc = 32'd4;
        endcase
    endtask

    task automatic push_word(input logic [31:0] d, input logic last);
        exp_t e;
        e.addr = m_addr;
        lanes(d, m_inc, m_addr[1:0], e.wd, e.be);
        m_cnt  = m_cnt + m_inc;
        e.cnt  = m_cnt;
        sb_q.push_back(e);
        m_addr = m_addr + m_inc;
        mem[wr_ptr[5:0]] = {last, d};
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic pulse_start(input logic [31:0] dest, input logic [2:0] code);
        @(negedge clk);
        dest_address = dest;
        address_inc  = code;
        MW_start     = 1'b1;
        start_cyc    = cyc;
        @(negedge clk);
        MW_start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp_cnt);
        int n = 0;
        while (!MW_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!MW_done) begin
            check_eq({tag, "_done_timeout"}, 0, 1);
        end else begin
            check_eq({tag, "_count_at_done"}, IC_ByteCount, exp_cnt);
            check_eq({tag, "_sb_drained"}, sb_q.size(), 0);
            @(negedge clk);
            check_eq({tag, "_done_width"}, MW_done, 0);
            check_eq({tag, "_count_held"}, IC_ByteCount, exp_cnt);
        end
    endtask

    // Monitor
    initial begin
        logic        cnt_pending = 1'b0;
        logic [31:0] cnt_next = '0;
        logic        stall_prev = 1'b0;
        logic        wr_prev = 1'b0;
        logic [31:0] h_addr = '0;
        logic [31:0] h_wd = '0;
        logic [3:0]  h_be = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (cnt_pending) begin
                    check_eq("bytecount_step", IC_ByteCount, cnt_next);
                    cnt_pending = 1'b0;
                end
                if (fifo_rdreq) check_eq("rdreq_when_empty", fifo_empty, 0);
                if (MW_write && !wr_prev) rise_log.push_back(cyc);
                if (MW_write && MW_waitrequest) begin
                    if (stall_prev) begin
                        check_eq("stall_addr_held", MW_address, h_addr);
                        check_eq("stall_data_held", MW_writedata, h_wd);
                        check_eq("stall_be_held", MW_byteenable, h_be);
                    end
                    check_eq("rdreq_in_stall", fifo_rdreq, 0);
                    h_addr = MW_address;
                    h_wd = MW_writedata;
                    h_be = MW_byteenable;
                    stall_prev = 1'b1;
                end else begin
                    stall_prev = 1'b0;
                end
                if (MW_write && !MW_waitrequest) begin
                    if (sb_q.size() == 0) begin
                        check_eq("unexpected_write", MW_address, 32'hFFFF_FFFF);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq("wr_addr", MW_address, e.addr);
                        check_eq("wr_data", MW_writedata, e.wd);
                        check_eq("wr_be", MW_byteenable, e.be);
                        cnt_next = e.cnt;
                        cnt_pending = 1'b1;
                    end
                    acc_log.push_back(cyc);
                    acc_total++;
                end
                if (MW_done) done_total++;
                wr_prev = MW_write;
            end else begin
                cnt_pending = 1'b0;
                stall_prev = 1'b0;
                wr_prev = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int pops0;
        int n;
        int dsave;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_write", MW_write, 0);
        check_eq("rst_rdreq", fifo_rdreq, 0);
        check_eq("rst_done", MW_done, 0);
        check_eq("rst_addr", MW_address, 0);
        check_eq("rst_be", MW_byteenable, 0);
        check_eq("rst_wd", MW_writedata, 0);
        check_eq("rst_count", IC_ByteCount, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // WORD, FIFO preloaded, no stall
        begin_stream(32'h1000, 3'b100);
        push_word(32'h0102_0304, 1'b0);
        push_word(32'h1112_1314, 1'b0);
        push_word(32'h2122_2324, 1'b0);
        push_word(32'h3132_3334, 1'b1);
        pulse_start(32'h1000, 3'b100);
        wait_done("word", 32'd16);
        check_eq("word_latency", rise_log[$] - start_cyc, 2);
        check_eq("word_back_to_back", acc_log[$] - acc_log[$-3], 3);

        // WORD with 3-cycle stall on the second write
        base = acc_total;
        pops0 = pop_total;
        stall_target = base + 1;
        stall_len = 3;
        begin_stream(32'h1000, 3'b100);
        push_word(32'hCAFE_0001, 1'b0);
        push_word(32'hCAFE_0002, 1'b0);
        push_word(32'hCAFE_0003, 1'b0);
        push_word(32'hCAFE_0004, 1'b1);
        pulse_start(32'h1000, 3'b100);
        wait_done("stall", 32'd16);
        check_eq("stall_gap", acc_log[$-2] - acc_log[$-3], 4);
        check_eq("stall_pops", pop_total - pops0, 4);
        stall_target = -1;

        // HW from a half-word offset
        begin_stream(32'h2002, 3'b010);
        push_word(32'hAAAA_1111, 1'b0);
        push_word(32'hBBBB_2222, 1'b1);
        pulse_start(32'h2002, 3'b010);
        wait_done("hw", 32'd4);

        // BYTE with FIFO underflow between words
        begin_stream(32'h3001, 3'b001);
        push_word(32'h0000_00A5, 1'b0);
        pulse_start(32'h3001, 3'b001);
        repeat (6) @(negedge clk);
        check_eq("byte_wait_no_write", MW_write, 0);
        push_word(32'h0000_005A, 1'b1);
        wait_done("byte", 32'd2);

        // Invalid unit select; second start mid-transfer is ignored
        base = acc_total;
        begin_stream(32'h4000, 3'b000);
        push_word(32'h1122_3344, 1'b0);
        push_word(32'h5566_7788, 1'b0);
        pulse_start(32'h4000, 3'b000);
        n = 0;
        while (acc_total < base + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("inv_two_writes", acc_total - base, 2);
        pulse_start(32'h9000, 3'b001);
        @(negedge clk);
        push_word(32'h99AA_BBCC, 1'b1);
        wait_done("inv", 32'd12);

        // Reset while a write is stalled
        base = acc_total;
        stall_target = base;
        stall_len = 100;
        begin_stream(32'h7000, 3'b100);
        push_word(32'h7777_0001, 1'b0);
        push_word(32'h7777_0002, 1'b0);
        pulse_start(32'h7000, 3'b100);
        n = 0;
        while (!MW_write && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("rstmid_in_write", MW_write, 1);
        @(negedge clk);
        dsave = done_total;
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("rstmid_write", MW_write, 0);
        check_eq("rstmid_count", IC_ByteCount, 0);
        check_eq("rstmid_done", MW_done, 0);
        @(negedge clk);
        stall_target = -1;
        sb_q.delete();
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rstmid_no_done", done_total, dsave);
        check_eq("rstmid_idle", MW_write, 0);
        begin_stream(32'h5000, 3'b100);
        push_word(32'hDEAD_BEEF, 1'b1);
        pulse_start(32'h5000, 3'b100);
        wait_done("fresh", 32'd4);

        check_eq("done_pulses", done_total, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
